mbox_resp: RTL and testbench
============================

MBOX_RESP -- requirements
Module: mbox_resp

Interface
REQ-001 Parameter SHALL be: MEM_TIMEOUT, default 15, memory-ack cycles allowed before NXM.
REQ-002 Parameter SHALL be: AW, default 23, physical address width (VMA bits 13:35).
REQ-003 Port SHALL be: clk  input  1  EBOX/MCL clock; all state on rising edge.
REQ-004 Port SHALL be: RESET  input  1  MR reset, asynchronous, active-high.
REQ-005 Port SHALL be: MBOX_CYC_REQ  input  1  EBOX cycle request, one-cycle pulse.
REQ-006 Port SHALL be: VMA  input  AW  request address.
REQ-007 Port SHALL be: LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE  input  1 each  cycle type, sampled with request.
REQ-008 Port SHALL be: VMA_ADR_ERR  input  1  address error, sampled with request.
REQ-009 Port SHALL be: MB_IN  input  36  write data, valid with a write request.
REQ-010 Port SHALL be: MEM_REQ, MEM_WE  output  1 each  backing-store strobe and write enable.
REQ-011 Port SHALL be: MEM_ADDR  output  AW; MEM_WDATA  output  36.
REQ-012 Port SHALL be: MEM_ACK  input  1; MEM_RDATA  input  36.
REQ-013 Port SHALL be: MBOX_RESP  output  1  one-cycle completion pulse.
REQ-014 Port SHALL be: AR_LOAD, ARX_LOAD  output  1 each  load strobes, coincident with MBOX_RESP.
REQ-015 Port SHALL be: MB_OUT  output  36  read data, valid while MBOX_RESP=1.
REQ-016 Port SHALL be: MB_WAIT  output  1  busy; high in every state except IDLE and PAUSED.
REQ-017 Port SHALL be: PAGE_FAIL, NXM  output  1 each  error pulses, coincident with MBOX_RESP.

Function
REQ-018 States SHALL be IDLE, RD, WR, PAUSED, RPW_WR and DONE.
REQ-019 In IDLE, an MBOX_CYC_REQ SHALL latch VMA, the type bits and MB_IN.
REQ-020 Request with VMA_ADR_ERR=1 SHALL skip memory -> DONE, then MBOX_RESP+PAGE_FAIL the next cycle with no AR/ARX load.
REQ-021 Read (LOAD_AR|LOAD_ARX, VMA_WRITE=0) -> RD; write only (VMA_WRITE=1, no load) -> WR; read-pause-write (load & VMA_PAUSE & VMA_WRITE) -> RD, then PAUSED.
REQ-022 Request with no type bit set SHALL -> DONE, giving a bare MBOX_RESP with no memory access.
REQ-023 In RD/WR/RPW_WR, MEM_REQ SHALL be high the cycle after entry and stay high until the cycle MEM_ACK is sampled.
REQ-024 MEM_ADDR and MEM_WDATA SHALL be stable from entry to ack; MEM_WE=1 only in WR/RPW_WR.
REQ-025 On MEM_ACK in RD, MEM_RDATA SHALL be registered into MB_OUT.
REQ-026 The state after RD ack SHALL be DONE (AR_LOAD/ARX_LOAD = latched LOAD_AR/LOAD_ARX) or PAUSED for RPW.
REQ-027 PAUSED SHALL emit MBOX_RESP with loads on entry, hold the latched address, and drop MB_WAIT.
REQ-028 In PAUSED, only an MBOX_CYC_REQ with VMA_WRITE=1 SHALL be accepted; it latches MB_IN, keeps the held address and -> RPW_WR.
REQ-029 A PAUSED request without VMA_WRITE SHALL be ignored.
REQ-030 RPW_WR ack and WR ack SHALL -> DONE -> IDLE; DONE emits MBOX_RESP only.
REQ-031 Request-to-response latency SHALL be memory ack latency + 2 clocks; a zero-wait ack gives MBOX_RESP 3 cycles after the request.
REQ-032 A 4-bit timeout counter SHALL clear on state entry and count while MEM_REQ is high.
REQ-033 When the counter reaches MEM_TIMEOUT without ack, the block SHALL drop MEM_REQ, -> DONE and pulse MBOX_RESP+NXM with MB_OUT=0 and no loads.
REQ-034 An ack coinciding with the timeout cycle SHALL win and give a normal completion.
REQ-035 MBOX_CYC_REQ in any state other than IDLE or PAUSED SHALL be ignored with no state change.
REQ-036 A request in the DONE->IDLE cycle SHALL not be accepted; the requester must await MB_WAIT=0.
REQ-037 MEM_ACK while MEM_REQ=0 SHALL be ignored.

Reset
REQ-038 RESET SHALL asynchronously force IDLE, counter=0, MB_OUT=0 and all outputs 0 (MEM_REQ, MEM_WE, MBOX_RESP, AR_LOAD, ARX_LOAD, MB_WAIT, PAGE_FAIL, NXM).
REQ-039 RESET mid-cycle SHALL abandon the access immediately with no response after deassertion.
REQ-040 The first request SHALL be accepted on the first clock after RESET falls.

Verification
REQ-041 Read: req VMA=0o1234, LOAD_AR=1, ack after 2 cycles with RDATA=0o123456701234 -> one MBOX_RESP+AR_LOAD with MB_OUT=0o123456701234, latency 4.
REQ-042 Write: req VMA_WRITE=1, MB_IN=0o777777000000, ack immediate -> MEM_WE=1, WDATA as given, MBOX_RESP 3 cycles after req, no loads.
REQ-043 RPW: read ack -> RESP+ARX_LOAD, MB_WAIT=0 in PAUSED; stray read req ignored; write req MB_IN=5 -> MEM_WE at same address, second RESP.
REQ-044 Faults: VMA_ADR_ERR=1 -> RESP+PAGE_FAIL 2 cycles after req, MEM_REQ never high; no ack -> NXM pulse after 15 MEM_REQ cycles; ack on cycle 15 -> normal read.
REQ-045 RESET asserted in RD with MEM_REQ=1 -> all outputs 0 immediately, no response; new read completes normally afterward.

Source files
------------

// File: rtl/mbox_resp_if.sv
// EBOX <-> MBOX request/response signals plus the backing-store port.
// slave: the MBOX response block; master: the requester/memory side.
interface mbox_resp_if #(
  parameter int AW = 23
);
  // EBOX request side
  logic          MBOX_CYC_REQ;
  logic [AW-1:0] VMA;
  logic          LOAD_AR;
  logic          LOAD_ARX;
  logic          VMA_PAUSE;
  logic          VMA_WRITE;
  logic          VMA_ADR_ERR;
  logic [35:0]   MB_IN;
  // backing store
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [35:0]   MEM_WDATA;
  logic          MEM_ACK;
  logic [35:0]   MEM_RDATA;
  // response side
  logic          MBOX_RESP;
  logic          AR_LOAD;
  logic          ARX_LOAD;
  logic [35:0]   MB_OUT;
  logic          MB_WAIT;
  logic          PAGE_FAIL;
  logic          NXM;

  modport slave (
    input  MBOX_CYC_REQ, VMA, LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE,
           VMA_ADR_ERR, MB_IN, MEM_ACK, MEM_RDATA,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MBOX_RESP, AR_LOAD,
           ARX_LOAD, MB_OUT, MB_WAIT, PAGE_FAIL, NXM
  );

  modport master (
    output MBOX_CYC_REQ, VMA, LOAD_AR, LOAD_ARX, VMA_PAUSE, VMA_WRITE,
           VMA_ADR_ERR, MB_IN, MEM_ACK, MEM_RDATA,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MBOX_RESP, AR_LOAD,
           ARX_LOAD, MB_OUT, MB_WAIT, PAGE_FAIL, NXM
  );
endinterface

// File: rtl/mbox_resp.sv
// MBOX response sequencer: accepts one EBOX memory cycle at a time, runs
// the backing-store handshake (read, write or read-pause-write), and
// returns a single-cycle MBOX_RESP with load/error strobes.
// All outputs are registered; MBOX_RESP appears the cycle after DONE, or
// on entry to PAUSED for the read half of a read-pause-write.
module mbox_resp #(
  parameter int MEM_TIMEOUT = 15,
  parameter int AW          = 23
) (
  input logic        clk,
  input logic        RESET,
  mbox_resp_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_PAUSED, S_RPW_WR, S_DONE
  } state_t;

  // what DONE has to report when it fires MBOX_RESP
  typedef enum logic [1:0] {
    K_BARE, K_LOAD, K_PF, K_NXM
  } kind_t;

  localparam logic [4:0] TO_LIM = 5'(MEM_TIMEOUT);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [35:0]   wdata_q, wdata_d;
  logic [35:0]   mb_out_q, mb_out_d;
  logic          ld_ar_q, ld_ar_d;
  logic          ld_arx_q, ld_arx_d;
  logic          rpw_q, rpw_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          resp_q, resp_d;
  logic          ar_load_q, ar_load_d;
  logic          arx_load_q, arx_load_d;
  logic          mb_wait_q, mb_wait_d;
  logic          pf_q, pf_d;
  logic          nxm_q, nxm_d;

  logic ack, timeout, req_load;

  // an ack only counts while we are actually strobing memory
  assign ack      = bus.MEM_ACK & mem_req_q;
  // last allowed MEM_REQ cycle is the one where the count is about to hit the limit
  assign timeout  = mem_req_q & (({1'b0, cnt_q} + 5'd1) >= TO_LIM);
  assign req_load = bus.LOAD_AR | bus.LOAD_ARX;

  assign bus.MEM_REQ   = mem_req_q;
  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.MBOX_RESP = resp_q;
  assign bus.AR_LOAD   = ar_load_q;
  assign bus.ARX_LOAD  = arx_load_q;
  assign bus.MB_OUT    = mb_out_q;
  assign bus.MB_WAIT   = mb_wait_q;
  assign bus.PAGE_FAIL = pf_q;
  assign bus.NXM       = nxm_q;

  // next-state, request latching and registered-output computation
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = mem_req_q ? cnt_q + 4'd1 : cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mb_out_d   = mb_out_q;
    ld_ar_d    = ld_ar_q;
    ld_arx_d   = ld_arx_q;
    rpw_d      = rpw_q;
    resp_d     = 1'b0;
    ar_load_d  = 1'b0;
    arx_load_d = 1'b0;
    pf_d       = 1'b0;
    nxm_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.MBOX_CYC_REQ) begin
          addr_d   = bus.VMA;
          wdata_d  = bus.MB_IN;
          ld_ar_d  = bus.LOAD_AR;
          ld_arx_d = bus.LOAD_ARX;
          rpw_d    = 1'b0;
          if (bus.VMA_ADR_ERR) begin
            state_d = S_DONE;
            kind_d  = K_PF;
          end else if (req_load && bus.VMA_PAUSE && bus.VMA_WRITE) begin
            state_d = S_RD;
            rpw_d   = 1'b1;
          end else if (bus.VMA_WRITE) begin
            // a write that also asks for a load but no pause is treated as a write
            state_d = S_WR;
          end else if (req_load) begin
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
            kind_d  = K_BARE;
          end
        end
      end

      S_RD: begin
        if (ack) begin
          mb_out_d = bus.MEM_RDATA;
          if (rpw_q) begin
            // read half of RPW responds right away, write half follows later
            state_d    = S_PAUSED;
            resp_d     = 1'b1;
            ar_load_d  = ld_ar_q;
            arx_load_d = ld_arx_q;
          end else begin
            state_d = S_DONE;
            kind_d  = K_LOAD;
          end
        end else if (timeout) begin
          state_d  = S_DONE;
          kind_d   = K_NXM;
          mb_out_d = '0;
        end
      end

      S_WR, S_RPW_WR: begin
        if (ack) begin
          state_d = S_DONE;
          kind_d  = K_BARE;
        end else if (timeout) begin
          state_d  = S_DONE;
          kind_d   = K_NXM;
          mb_out_d = '0;
        end
      end

      S_PAUSED: begin
        // only the write half is accepted; address stays from the read half
        if (bus.MBOX_CYC_REQ && bus.VMA_WRITE) begin
          wdata_d = bus.MB_IN;
          rpw_d   = 1'b0;
          state_d = S_RPW_WR;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        resp_d     = 1'b1;
        ar_load_d  = (kind_q == K_LOAD) & ld_ar_q;
        arx_load_d = (kind_q == K_LOAD) & ld_arx_q;
        pf_d       = (kind_q == K_PF);
        nxm_d      = (kind_q == K_NXM);
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 4'd0;

    mem_req_d = (state_d == S_RD) || (state_d == S_WR) || (state_d == S_RPW_WR);
    mem_we_d  = (state_d == S_WR) || (state_d == S_RPW_WR);
    mb_wait_d = !((state_d == S_IDLE) || (state_d == S_PAUSED));
  end

  // state and output registers, cleared asynchronously by MR reset
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      kind_q     <= K_BARE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mb_out_q   <= '0;
      ld_ar_q    <= 1'b0;
      ld_arx_q   <= 1'b0;
      rpw_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      resp_q     <= 1'b0;
      ar_load_q  <= 1'b0;
      arx_load_q <= 1'b0;
      mb_wait_q  <= 1'b0;
      pf_q       <= 1'b0;
      nxm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mb_out_q   <= mb_out_d;
      ld_ar_q    <= ld_ar_d;
      ld_arx_q   <= ld_arx_d;
      rpw_q      <= rpw_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      resp_q     <= resp_d;
      ar_load_q  <= ar_load_d;
      arx_load_q <= arx_load_d;
      mb_wait_q  <= mb_wait_d;
      pf_q       <= pf_d;
      nxm_q      <= nxm_d;
    end
  end

endmodule

// File: tb/tb_mbox_resp.sv
// Bench for mbox_resp: table of single-request vectors plus hand sequences
// for read-pause-write, ignored requests, stray acks and mid-access reset.
// Expected responses go into a scoreboard queue when a request is issued
// and are popped by a monitor whenever MBOX_RESP fires.
module tb_mbox_resp;

  localparam int AW = 23;

  logic clk = 1'b0;
  logic RESET;
  int   cyc = 0;

  mbox_resp_if #(.AW(AW)) bus ();

  mbox_resp #(.MEM_TIMEOUT(15), .AW(AW)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    int          cyc;
    bit          ar, arx, pf, nxm, chk_out;
    logic [35:0] mb_out;
  } exp_t;

  exp_t sb[$];

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.MBOX_RESP === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", 64'(cyc),          64'(e.cyc));
        chk("ar_load",    64'(bus.AR_LOAD),  64'(e.ar));
        chk("arx_load",   64'(bus.ARX_LOAD), 64'(e.arx));
        chk("page_fail",  64'(bus.PAGE_FAIL),64'(e.pf));
        chk("nxm",        64'(bus.NXM),      64'(e.nxm));
        if (e.chk_out) chk("mb_out", 64'(bus.MB_OUT), 64'(e.mb_out));
      end
    end else if ((bus.AR_LOAD | bus.ARX_LOAD | bus.PAGE_FAIL | bus.NXM) !== 1'b0) begin
      total++; bad++;
      $display("FAIL strobe_without_resp cyc=%0d", cyc);
    end
  end

  // ---------------- memory responder ----------------
  bit          ack_en = 1'b1;
  int          ack_dly = 0;
  logic [35:0] rdata = '0;
  bit          stray = 1'b0;
  int          rq_cnt = 0;
  int          mem_req_cycles = 0;
  int          acks = 0;
  logic        last_we = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [35:0] last_wdata = '0;

  always @(negedge clk) begin
    if (bus.MEM_REQ === 1'b1) begin
      rq_cnt++;
      mem_req_cycles++;
      if (ack_en && (rq_cnt - 1 == ack_dly)) begin
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = rdata;
        acks++;
        last_we    = bus.MEM_WE;
        last_addr  = bus.MEM_ADDR;
        last_wdata = bus.MEM_WDATA;
      end else begin
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;
      end
    end else begin
      rq_cnt        = 0;
      bus.MEM_ACK   = stray;
      bus.MEM_RDATA = stray ? 36'o666666666666 : 36'd0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit rel, input bit lar, input bit larx, input bit pse,
                       input bit wr, input bit aerr, input logic [AW-1:0] vma,
                       input logic [35:0] mbin, output int rc);
    @(negedge clk);
    if (rel) RESET = 1'b0;
    bus.LOAD_AR      = lar;
    bus.LOAD_ARX     = larx;
    bus.VMA_PAUSE    = pse;
    bus.VMA_WRITE    = wr;
    bus.VMA_ADR_ERR  = aerr;
    bus.VMA          = vma;
    bus.MB_IN        = mbin;
    bus.MBOX_CYC_REQ = 1'b1;
    rc = cyc;
    @(negedge clk);
    bus.MBOX_CYC_REQ = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic exp_t mk(input int c, input bit ar, input bit arx, input bit pf,
                              input bit nxm, input bit co, input logic [35:0] mo);
    exp_t e;
    e.cyc = c; e.ar = ar; e.arx = arx; e.pf = pf; e.nxm = nxm;
    e.chk_out = co; e.mb_out = mo;
    return e;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          lar, larx, pse, wr, aerr;
    logic [AW-1:0] vma;
    logic [35:0] mbin, rdat;
    bit          aen;
    int          dly;
    int          lat;
    bit          ar, arx, pf, nxm, chk_out;
    logic [35:0] mb_out;
    bit          mem;
    int          reqc;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];

  initial begin
    vec_t v;
    int rc, rc0, ak0;
    logic [35:0] last_rd;

    //        lar larx pse wr aer vma           mbin              rdat              aen dly lat ar arx pf nxm co mb_out            mem reqc
    vt[0]  = '{1, 0, 0, 0, 0, 23'o1234,     36'd0,            36'o123456701234, 1, 1,  4, 1, 0, 0, 0, 1, 36'o123456701234, 1, 2};
    vt[1]  = '{0, 0, 0, 1, 0, 23'o7000,     36'o777777000000, 36'd0,            1, 0,  3, 0, 0, 0, 0, 0, 36'd0,            1, 1};
    vt[2]  = '{0, 1, 0, 0, 0, 23'o55,       36'd0,            36'o252525252525, 1, 0,  3, 0, 1, 0, 0, 1, 36'o252525252525, 1, 1};
    vt[3]  = '{1, 1, 0, 0, 0, 23'o3,        36'd0,            36'o000000000777, 1, 3,  6, 1, 1, 0, 0, 1, 36'o000000000777, 1, 4};
    vt[4]  = '{1, 0, 0, 0, 1, 23'o1000,     36'd0,            36'o111,          1, 0,  2, 0, 0, 1, 0, 0, 36'd0,            0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 23'o2,        36'd0,            36'd0,            1, 0,  2, 0, 0, 0, 0, 0, 36'd0,            0, 0};
    vt[6]  = '{1, 0, 0, 0, 0, 23'o3000,     36'd0,            36'o777,          0, 0, 17, 0, 0, 0, 1, 1, 36'd0,            0, 15};
    vt[7]  = '{1, 0, 0, 0, 0, 23'o3001,     36'd0,            36'o707070707070, 1, 14,17, 1, 0, 0, 0, 1, 36'o707070707070, 1, 15};
    vt[8]  = '{0, 0, 0, 1, 0, 23'o4000,     36'o42,           36'd0,            0, 0, 17, 0, 0, 0, 1, 1, 36'd0,            0, 15};
    vt[9]  = '{0, 0, 0, 1, 0, 23'o37777777, 36'o123,          36'd0,            1, 2,  5, 0, 0, 0, 0, 0, 36'd0,            1, 3};
    vt[10] = '{0, 0, 0, 1, 1, 23'o5000,     36'o77,           36'd0,            1, 0,  2, 0, 0, 1, 0, 0, 36'd0,            0, 0};

    RESET = 1'b1;
    bus.MBOX_CYC_REQ = 1'b0;
    bus.LOAD_AR = 1'b0; bus.LOAD_ARX = 1'b0; bus.VMA_PAUSE = 1'b0;
    bus.VMA_WRITE = 1'b0; bus.VMA_ADR_ERR = 1'b0;
    bus.VMA = '0; bus.MB_IN = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req",  64'(bus.MEM_REQ),   64'd0);
    chk("rst_mem_we",   64'(bus.MEM_WE),    64'd0);
    chk("rst_resp",     64'(bus.MBOX_RESP), 64'd0);
    chk("rst_ar",       64'(bus.AR_LOAD),   64'd0);
    chk("rst_arx",      64'(bus.ARX_LOAD),  64'd0);
    chk("rst_wait",     64'(bus.MB_WAIT),   64'd0);
    chk("rst_pf",       64'(bus.PAGE_FAIL), 64'd0);
    chk("rst_nxm",      64'(bus.NXM),       64'd0);
    chk("rst_mb_out",   64'(bus.MB_OUT),    64'd0);

    // table vectors; the first request goes in on the first clock after reset falls
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      ack_en = v.aen; ack_dly = v.dly; rdata = v.rdat;
      rc0 = mem_req_cycles; ak0 = acks;
      issue(i == 0, v.lar, v.larx, v.pse, v.wr, v.aerr, v.vma, v.mbin, rc);
      sb.push_back(mk(rc + v.lat, v.ar, v.arx, v.pf, v.nxm, v.chk_out, v.mb_out));
      drain(100);
      chk($sformatf("v%0d_reqc", i), 64'(mem_req_cycles - rc0), 64'(v.reqc));
      if (v.mem) begin
        chk($sformatf("v%0d_acks", i), 64'(acks - ak0), 64'd1);
        chk($sformatf("v%0d_we", i),   64'(last_we),   64'(v.wr));
        chk($sformatf("v%0d_addr", i), 64'(last_addr), 64'(v.vma));
        if (v.wr) chk($sformatf("v%0d_wdata", i), 64'(last_wdata), 64'(v.mbin));
      end
    end

    // read-pause-write
    ack_en = 1'b1; ack_dly = 0; rdata = 36'o414243444546;
    issue(0, 0, 1, 1, 1, 0, 23'o4567, 36'd0, rc);
    sb.push_back(mk(rc + 2, 0, 1, 0, 0, 1, 36'o414243444546));
    drain(50);
    chk("rpw_rd_we",     64'(last_we),     64'd0);
    chk("paused_wait",   64'(bus.MB_WAIT), 64'd0);
    chk("paused_memreq", 64'(bus.MEM_REQ), 64'd0);
    rc0 = mem_req_cycles;
    issue(0, 1, 0, 0, 0, 0, 23'o1111, 36'd0, rc);   // stray read: ignored
    repeat (3) @(negedge clk);
    chk("paused_ign_reqc", 64'(mem_req_cycles - rc0), 64'd0);
    chk("paused_ign_wait", 64'(bus.MB_WAIT), 64'd0);
    ak0 = acks;
    issue(0, 0, 0, 0, 1, 0, 23'o2222, 36'd5, rc);
    sb.push_back(mk(rc + 3, 0, 0, 0, 0, 0, 36'd0));
    drain(50);
    chk("rpw_wr_acks",  64'(acks - ak0), 64'd1);
    chk("rpw_wr_we",    64'(last_we),    64'd1);
    chk("rpw_wr_addr",  64'(last_addr),  64'(23'o4567));
    chk("rpw_wr_wdata", 64'(last_wdata), 64'd5);

    // requests while busy (in RD and in DONE) are dropped
    ack_en = 1'b1; ack_dly = 3; last_rd = 36'o135713571357; rdata = last_rd;
    rc0 = mem_req_cycles; ak0 = acks;
    issue(0, 1, 0, 0, 0, 0, 23'o600, 36'd0, rc);
    sb.push_back(mk(rc + 6, 1, 0, 0, 0, 1, last_rd));
    issue(0, 0, 0, 0, 1, 0, 23'o700, 36'o1, rc0);   // lands in RD
    rc0 = mem_req_cycles - 2;                       // restore baseline (two RD cycles counted so far)
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 0, 23'o701, 36'o2, ak0);   // lands in DONE
    ak0 = acks - 1;
    drain(50);
    chk("busy_reqc", 64'(mem_req_cycles - rc0), 64'd4);
    chk("busy_acks", 64'(acks - ak0),           64'd1);
    chk("busy_we",   64'(last_we),              64'd0);
    chk("busy_addr", 64'(last_addr),            64'(23'o600));

    // MEM_ACK while MEM_REQ is low does nothing
    rc0 = mem_req_cycles;
    @(posedge clk); #2 stray = 1'b1;
    repeat (2) @(posedge clk);
    #2 stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_wait",   64'(bus.MB_WAIT),            64'd0);
    chk("stray_memreq", 64'(mem_req_cycles - rc0),   64'd0);
    chk("stray_mb_out", 64'(bus.MB_OUT),             64'(last_rd));

    // reset in the middle of a read, then a clean read right after release
    ack_en = 1'b0;
    issue(0, 1, 0, 0, 0, 0, 23'o4321, 36'd0, rc);
    @(negedge clk);
    chk("rd_active", 64'(bus.MEM_REQ), 64'd1);
    RESET = 1'b1;
    #1;
    chk("arst_mem_req", 64'(bus.MEM_REQ),   64'd0);
    chk("arst_wait",    64'(bus.MB_WAIT),   64'd0);
    chk("arst_resp",    64'(bus.MBOX_RESP), 64'd0);
    chk("arst_mb_out",  64'(bus.MB_OUT),    64'd0);
    chk("arst_we",      64'(bus.MEM_WE),    64'd0);
    repeat (2) @(negedge clk);
    ack_en = 1'b1; ack_dly = 0; rdata = 36'o606060606060;
    rc0 = mem_req_cycles;
    issue(1, 1, 0, 0, 0, 0, 23'o4444, 36'd0, rc);
    sb.push_back(mk(rc + 3, 1, 0, 0, 0, 1, 36'o606060606060));
    drain(50);
    chk("post_rst_reqc", 64'(mem_req_cycles - rc0), 64'd1);
    chk("post_rst_addr", 64'(last_addr),            64'(23'o4444));

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
